bk_memarb: RTL



---
 rtl/bk_memarb_pkg.sv | 25 ++
 rtl/bk_memarb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bk_memarb_pkg.sv
// Shared constants for the BK memory arbiter: FSM encodings, screen base and
// SRAM write lane selection.
package bk_memarb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VID    = 3'd1;
    localparam logic [2:0] ST_CPU_RD = 3'd2;
    localparam logic [2:0] ST_CPU_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [16:0] VID_BASE_DEF = 17'o040000;
    localparam logic        CTL_IDLE     = 1'b1;

    // Returns {ub_n, lb_n}; odd byte address selects the upper lane.
    function automatic logic [1:0] wr_lanes_n(input logic byte_acc, input logic a0);
        logic [1:0] r;
        if (byte_acc) begin
            r = {~a0, a0};
        end else begin
            r = 2'b00;
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_memarb.sv
// Single-port async SRAM arbiter between the BK core bus and video refresh.
// Every SRAM-facing and core-facing output comes straight from a flop.
module bk_memarb
    import bk_memarb_pkg::*;
#(
    parameter int             AW       = 17,
    parameter int             WAIT     = 2,
    parameter logic [AW-1:0]  VID_BASE = AW'(VID_BASE_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wt,
    input  logic          cpu_byte,
    input  logic [AW-1:0] cpu_adr,
    input  logic [15:0]   cpu_wdata,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_reply,
    input  logic          vid_req,
    input  logic [12:0]   vid_adr,
    output logic [15:0]   vid_rdata,
    output logic          vid_ack,
    output logic [AW-2:0] sram_a,
    input  logic [15:0]   sram_dq_i,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam int            WW    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WAIT);
    localparam logic [WW-1:0] WONE  = WW'(1);

    logic [2:0]    state;
    logic [WW-1:0] wcnt;
    logic          last_vid;

    logic          cpu_pend;
    logic          vid_pend;
    logic          grant_vid;
    logic          grant_cpu;
    logic [AW-2:0] vid_word;
    logic [1:0]    lanes_n;

    // Request qualification and fair grant; the ack/reply terms mask a requester
    // that has been served but has not yet released its level strobe.
    always_comb begin
        cpu_pend  = (cpu_rd | cpu_wt) & ~cpu_reply;
        vid_pend  = vid_req & ~vid_ack;
        grant_vid = vid_pend & (~cpu_pend | ~last_vid);
        grant_cpu = cpu_pend & ~grant_vid;
        vid_word  = VID_BASE[AW-1:1] + {{(AW-14){1'b0}}, vid_adr};
        lanes_n   = wr_lanes_n(cpu_byte, cpu_adr[0]);
    end

    // Arbitration FSM; SRAM controls are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wcnt       <= {WW{1'b0}};
            last_vid   <= 1'b0;
            cpu_reply  <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= 16'h0000;
            vid_rdata  <= 16'h0000;
            sram_a     <= {(AW-1){1'b0}};
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= CTL_IDLE;
            sram_oe_n  <= CTL_IDLE;
            sram_ub_n  <= CTL_IDLE;
            sram_lb_n  <= CTL_IDLE;
        end else begin
            vid_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wcnt <= {WW{1'b0}};
                    if (grant_vid) begin
                        state     <= ST_VID;
                        sram_a    <= vid_word;
                        sram_oe_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                    end else if (grant_cpu) begin
                        last_vid <= 1'b0;
                        sram_a   <= cpu_adr[AW-1:1];
                        if (cpu_wt) begin
                            // With no wait states the single cycle must carry the pulse.
                            state      <= ST_CPU_WR;
                            sram_dq_o  <= cpu_wdata;
                            sram_dq_oe <= 1'b1;
                            sram_we_n  <= (WAIT == 0) ? 1'b0 : 1'b1;
                            sram_ub_n  <= lanes_n[1];
                            sram_lb_n  <= lanes_n[0];
                        end else begin
                            state     <= ST_CPU_RD;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end
                    end
                end
                ST_VID: begin
                    if (wcnt == WLAST) begin
                        vid_rdata <= sram_dq_i;
                        vid_ack   <= 1'b1;
                        last_vid  <= 1'b1;
                        sram_oe_n <= CTL_IDLE;
                        sram_ub_n <= CTL_IDLE;
                        sram_lb_n <= CTL_IDLE;
                        state     <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + WONE;
                    end
                end
                ST_CPU_RD: begin
                    if (wcnt == WLAST) begin
                        cpu_rdata <= sram_dq_i;
                        sram_oe_n <= CTL_IDLE;
                        sram_ub_n <= CTL_IDLE;
                        sram_lb_n <= CTL_IDLE;
                        state     <= ST_DONE;
                    end else begin
                        wcnt <= wcnt + WONE;
                    end
                end
                ST_CPU_WR: begin
                    if (wcnt == WLAST) begin
                        sram_we_n  <= CTL_IDLE;
                        sram_dq_oe <= 1'b0;
                        sram_ub_n  <= CTL_IDLE;
                        sram_lb_n  <= CTL_IDLE;
                        state      <= ST_DONE;
                    end else begin
                        wcnt      <= wcnt + WONE;
                        sram_we_n <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (cpu_rd | cpu_wt) begin
                        cpu_reply <= 1'b1;
                    end else begin
                        cpu_reply <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cpu_reply  <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= CTL_IDLE;
                    sram_oe_n  <= CTL_IDLE;
                    sram_ub_n  <= CTL_IDLE;
                    sram_lb_n  <= CTL_IDLE;
                end
            endcase
        end
    end

endmodule
